// File: rtl/alu32_pkg.sv
// Shared constants and stage-1 register layout for the ALU32 carry-increment adder.
package alu32_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  // Everything stage 2 needs to finish the add; slice 0 is already final.
  typedef struct packed {
    logic                              a_msb;
    logic                              b_msb;
    logic [NSLICE-1:1]                 g;
    logic [NSLICE-1:1][SLICE-1:0]      r;
    logic                              c0;
    logic [SLICE-1:0]                  s0;
  } s1_t;

endpackage

// File: rtl/cia_slice8.sv
// 8-bit conditional incrementer used to apply a late slice carry-in.
module cia_slice8
  import alu32_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/cia32_pipe.sv
// Two-stage 32-bit carry-increment adder: stage 1 forms per-slice carry-0 sums,
// stage 2 ripples slice carries through incrementers and registers sum and flags.
module cia32_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = alu32_pkg::NSLICE;

  if (WIDTH != alu32_pkg::WIDTH || SLICE != alu32_pkg::SLICE) begin : g_param_check
    $error("cia32_pipe supports only WIDTH=32 and SLICE=8");
  end

  alu32_pkg::s1_t   s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic s2_adv, s1_adv, in_xfer;

  // Ready depends only on registered state and out_ready, never on in_valid.
  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid & s1_adv;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    s1_d = s1_q;
    if (in_xfer) begin
      {s1_d.c0, s1_d.s0} = {1'b0, a[SLICE-1:0]} + {1'b0, b[SLICE-1:0]}
                         + {{SLICE{1'b0}}, cin};
      for (int k = 1; k < NSLICE; k++) begin
        {s1_d.g[k], s1_d.r[k]} = {1'b0, a[k*SLICE +: SLICE]}
                               + {1'b0, b[k*SLICE +: SLICE]};
      end
      s1_d.a_msb = a[WIDTH-1];
      s1_d.b_msb = b[WIDTH-1];
    end
  end

  logic [SLICE-1:0] inc1, inc2, inc3;
  logic             ci1, ci2, ci3;
  logic             ic1, ic2, ic3;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  // A raw slice carry and an increment carry never coincide, so OR is exact.
  assign ci1 = s1_q.c0;
  cia_slice8 u_slice1 (.a(s1_q.r[1]), .cin(ci1), .sum(inc1), .cout(ic1));
  assign ci2 = s1_q.g[1] | ic1;
  cia_slice8 u_slice2 (.a(s1_q.r[2]), .cin(ci2), .sum(inc2), .cout(ic2));
  assign ci3 = s1_q.g[2] | ic2;
  cia_slice8 u_slice3 (.a(s1_q.r[3]), .cin(ci3), .sum(inc3), .cout(ic3));

  assign sum_c  = {inc3, inc2, inc1, s1_q.s0};
  assign cout_c = s1_q.g[3] | ic3;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    if (in_xfer)     s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    // Result registers only load real data, so bubbles leave sum/flags untouched.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = sum_c;
        cout_d = cout_c;
        ovf_d  = (s1_q.a_msb == s1_q.b_msb) & (sum_c[WIDTH-1] != s1_q.a_msb);
        zero_d = ~|sum_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath is cleared along with the valids so sum and flags read 0, not X, out of reset.
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from pre-edge values.
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
